// File: rtl/soc_ctrl_pkg.sv
// soc_ctrl_pkg: shared state and error-cause types for the SoC run sequencer
package soc_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, RESET, RUN, DRAIN, DONE, FAIL} run_state_e;
  typedef enum logic [1:0] {ERR_NONE, ERR_TIMEOUT, ERR_STALL, ERR_ABORT} run_err_e;
endpackage

// File: rtl/pc_stall_detect.sv
// pc_stall_detect: flags STALL_CYCLES consecutive cycles of an unchanged fetch address
module pc_stall_detect #(
  parameter int STALL_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic [31:0] instr_addr_i,
  output logic        stall_o
);
  localparam int W = $clog2(STALL_CYCLES + 1);
  localparam logic [W-1:0] LIM = W'(STALL_CYCLES);
  logic [31:0] prev_q, prev_d;
  logic        valid_q, valid_d;
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    prev_d  = instr_addr_i;
    valid_d = !clear_i;
    cnt_d   = (clear_i || !valid_q || instr_addr_i != prev_q) ? '0 :
              (cnt_q == LIM) ? cnt_q : cnt_q + 1'b1;
    stall_o = !clear_i && cnt_d == LIM;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      prev_q  <= prev_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: rtl/soc_run_ctrl.sv
// soc_run_ctrl: reset/fetch-enable sequencer with watchdog, stall detect, result capture and retries
module soc_run_ctrl
  import soc_ctrl_pkg::*;
#(
  parameter int RST_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 100,
  parameter int STALL_CYCLES   = 16,
  parameter int DRAIN_CYCLES   = 1,
  parameter int MAX_RETRIES    = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        abort_i,
  output logic        core_rst_no,
  output logic        fetch_enable_o,
  input  logic [31:0] mem_flag_i,
  input  logic [31:0] mem_result_i,
  input  logic [31:0] instr_addr_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [1:0]  err_o,
  output logic [31:0] result_o,
  output logic [31:0] cycles_o,
  output logic [2:0]  retries_o
);
  run_state_e  state_q, state_d;
  run_err_e    err_q, err_d;
  logic [31:0] wait_q, wait_d, result_q, result_d, cycles_q, cycles_d;
  logic [2:0]  retries_q, retries_d;
  logic        core_rst_q, core_rst_d, fetch_q, fetch_d, busy_q, busy_d, done_q, done_d;
  logic        stall, timeout;
  pc_stall_detect #(.STALL_CYCLES(STALL_CYCLES)) u_stall (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (state_q != RUN),
    .instr_addr_i(instr_addr_i),
    .stall_o     (stall)
  );
  assign timeout = cycles_q >= 32'(TIMEOUT_CYCLES);
  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    wait_d    = wait_q;
    result_d  = result_q;
    cycles_d  = cycles_q;
    retries_d = retries_q;
    if (abort_i) begin
      state_d = IDLE;
      err_d   = busy_q ? ERR_ABORT : err_q;
    end else if (start_i && !busy_q) begin
      state_d   = RESET;
      err_d     = ERR_NONE;
      wait_d    = '0;
      result_d  = '0;
      cycles_d  = '0;
      retries_d = '0;
    end else if (state_q == RESET) begin
      wait_d = wait_q + 1;
      if (wait_q == 32'(RST_CYCLES - 1)) begin
        state_d  = RUN;
        cycles_d = 32'd1;
      end
    end else if (state_q == RUN) begin
      if (|mem_flag_i) begin
        state_d = DRAIN;
        wait_d  = '0;
      end else if (timeout || stall) begin
        if (retries_q < 3'(MAX_RETRIES)) begin
          retries_d = retries_q + 1'b1;
          state_d   = RESET;
          wait_d    = '0;
        end else begin
          state_d = FAIL;
          err_d   = timeout ? ERR_TIMEOUT : ERR_STALL;
        end
      end else begin
        cycles_d = (&cycles_q) ? cycles_q : cycles_q + 1;
      end
    end else if (state_q == DRAIN) begin
      wait_d = wait_q + 1;
      if (wait_q == 32'(DRAIN_CYCLES)) begin
        state_d  = DONE;
        result_d = mem_result_i;
      end
    end
    core_rst_d = state_d inside {RUN, DRAIN, DONE};
    fetch_d    = state_d == RUN;
    busy_d     = state_d inside {RESET, RUN, DRAIN};
    done_d     = state_d == DONE;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      err_q      <= ERR_NONE;
      wait_q     <= '0;
      result_q   <= '0;
      cycles_q   <= '0;
      retries_q  <= '0;
      core_rst_q <= 1'b0;
      fetch_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      err_q      <= err_d;
      wait_q     <= wait_d;
      result_q   <= result_d;
      cycles_q   <= cycles_d;
      retries_q  <= retries_d;
      core_rst_q <= core_rst_d;
      fetch_q    <= fetch_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end
  assign core_rst_no    = core_rst_q;
  assign fetch_enable_o = fetch_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign err_o          = err_q;
  assign result_o       = result_q;
  assign cycles_o       = cycles_q;
  assign retries_o      = retries_q;
endmodule

// File: tb/tb_soc_run_ctrl.sv
// tb_soc_run_ctrl: directed self-checking bench for soc_run_ctrl with default parameters
module tb_soc_run_ctrl;
  logic        clk_i = 1'b0, rst_i, start_i, abort_i;
  logic        core_rst_no, fetch_enable_o, busy_o, done_o;
  logic [31:0] mem_flag_i, mem_result_i, instr_addr_i, result_o, cycles_o;
  logic [1:0]  err_o;
  logic [2:0]  retries_o;
  logic        inc;
  int          tests = 0, fails = 0;
  soc_run_ctrl dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .abort_i       (abort_i),
    .core_rst_no   (core_rst_no),
    .fetch_enable_o(fetch_enable_o),
    .mem_flag_i    (mem_flag_i),
    .mem_result_i  (mem_result_i),
    .instr_addr_i  (instr_addr_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o),
    .result_o      (result_o),
    .cycles_o      (cycles_o),
    .retries_o     (retries_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
      if (inc) instr_addr_i = instr_addr_i + 32'd4;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic pulse_start();
    start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
  endtask
  task automatic chk_ctl(input string tag, input logic c, input logic f, input logic b, input logic d);
    chk({tag, ".core_rst_n"}, 32'(core_rst_no), 32'(c));
    chk({tag, ".fetch"}, 32'(fetch_enable_o), 32'(f));
    chk({tag, ".busy"}, 32'(busy_o), 32'(b));
    chk({tag, ".done"}, 32'(done_o), 32'(d));
  endtask
  task automatic chk_reset_vals(input string tag);
    chk_ctl(tag, 0, 0, 0, 0);
    chk({tag, ".err"}, 32'(err_o), 0);
    chk({tag, ".result"}, result_o, 0);
    chk({tag, ".cycles"}, cycles_o, 0);
    chk({tag, ".retries"}, 32'(retries_o), 0);
  endtask
  initial begin
    rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; inc = 1'b0;
    mem_flag_i = '0; mem_result_i = '0; instr_addr_i = '0;
    tick(2);
    chk_reset_vals("rst");
    rst_i = 1'b0;
    inc = 1'b1;
    tick(1);
    pulse_start();
    chk_ctl("t1.reset0", 0, 0, 1, 0);
    tick(3);
    chk_ctl("t1.reset3", 0, 0, 1, 0);
    tick(1);
    chk_ctl("t1.run1", 1, 1, 1, 0);
    chk("t1.cyc1", cycles_o, 1);
    tick(8);
    start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
    chk("t1.start_busy_cyc", cycles_o, 10);
    chk_ctl("t1.start_busy", 1, 1, 1, 0);
    tick(10);
    chk("t1.cyc20", cycles_o, 20);
    mem_flag_i = 32'd1; mem_result_i = 32'hDEADBEEF;
    tick(1);
    mem_flag_i = '0;
    chk_ctl("t1.drain0", 1, 0, 1, 0);
    tick(1);
    chk_ctl("t1.drain1", 1, 0, 1, 0);
    tick(1);
    chk_ctl("t1.done", 1, 0, 0, 1);
    chk("t1.result", result_o, 32'hDEADBEEF);
    chk("t1.cycles", cycles_o, 20);
    chk("t1.err", 32'(err_o), 0);
    chk("t1.retries", 32'(retries_o), 0);
    pulse_start();
    chk("t2.clr_result", result_o, 0);
    chk("t2.clr_cycles", cycles_o, 0);
    chk_ctl("t2.reset", 0, 0, 1, 0);
    tick(4);
    chk("t2.a1_cyc1", cycles_o, 1);
    tick(99);
    chk("t2.a1_cyc100", cycles_o, 100);
    chk_ctl("t2.a1_run", 1, 1, 1, 0);
    tick(1);
    chk_ctl("t2.retry_reset", 0, 0, 1, 0);
    chk("t2.retries", 32'(retries_o), 1);
    chk("t2.cyc_kept", cycles_o, 100);
    tick(3);
    chk_ctl("t2.retry_reset3", 0, 0, 1, 0);
    tick(1);
    chk("t2.a2_cyc1", cycles_o, 1);
    tick(99);
    chk_ctl("t2.a2_run", 1, 1, 1, 0);
    tick(1);
    chk_ctl("t2.fail", 0, 0, 0, 0);
    chk("t2.err", 32'(err_o), 1);
    chk("t2.fail_retries", 32'(retries_o), 1);
    chk("t2.fail_cyc", cycles_o, 100);
    inc = 1'b0;
    instr_addr_i = 32'h80;
    pulse_start();
    chk("t3.err_clr", 32'(err_o), 0);
    chk("t3.ret_clr", 32'(retries_o), 0);
    tick(4);
    chk("t3.a1_cyc1", cycles_o, 1);
    tick(16);
    chk_ctl("t3.a1_cyc17", 1, 1, 1, 0);
    tick(1);
    chk_ctl("t3.retry", 0, 0, 1, 0);
    chk("t3.retries", 32'(retries_o), 1);
    chk("t3.cyc_kept", cycles_o, 17);
    tick(4);
    chk("t3.a2_cyc1", cycles_o, 1);
    tick(16);
    chk_ctl("t3.a2_cyc17", 1, 1, 1, 0);
    tick(1);
    chk_ctl("t3.fail", 0, 0, 0, 0);
    chk("t3.err", 32'(err_o), 2);
    inc = 1'b1;
    pulse_start();
    tick(4);
    tick(99);
    chk("t4.cyc100", cycles_o, 100);
    mem_flag_i = 32'h8000_0000; mem_result_i = 32'h12345678;
    tick(1);
    mem_flag_i = '0;
    chk_ctl("t4.drain", 1, 0, 1, 0);
    chk("t4.retries", 32'(retries_o), 0);
    tick(2);
    chk_ctl("t4.done", 1, 0, 0, 1);
    chk("t4.err", 32'(err_o), 0);
    chk("t4.cycles", cycles_o, 100);
    chk("t4.result", result_o, 32'h12345678);
    pulse_start();
    tick(4);
    tick(9);
    chk("t5.cyc10", cycles_o, 10);
    abort_i = 1'b1; start_i = 1'b1;
    tick(1);
    abort_i = 1'b0; start_i = 1'b0;
    chk_ctl("t5.abort", 0, 0, 0, 0);
    chk("t5.err", 32'(err_o), 3);
    pulse_start();
    chk("t5.err_clr", 32'(err_o), 0);
    chk_ctl("t5.restart", 0, 0, 1, 0);
    tick(4);
    mem_flag_i = 32'd1; mem_result_i = 32'hCAFEF00D;
    tick(1);
    mem_flag_i = '0;
    tick(2);
    chk_ctl("t5.done", 1, 0, 0, 1);
    chk("t5.result", result_o, 32'hCAFEF00D);
    chk("t5.cycles", cycles_o, 1);
    abort_i = 1'b1;
    tick(1);
    abort_i = 1'b0;
    chk_ctl("t5.abort_done", 0, 0, 0, 0);
    chk("t5.abort_done_err", 32'(err_o), 0);
    chk("t5.abort_done_res", result_o, 32'hCAFEF00D);
    pulse_start();
    tick(4);
    mem_flag_i = 32'd1; mem_result_i = 32'h55AA55AA;
    tick(1);
    mem_flag_i = '0;
    chk_ctl("t6.drain", 1, 0, 1, 0);
    rst_i = 1'b1; abort_i = 1'b1;
    tick(1);
    rst_i = 1'b0; abort_i = 1'b0;
    chk_reset_vals("t6.rst");
    tick(3);
    chk_reset_vals("t6.idle");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
